// File: rtl/m2_pkg.sv
// Shared types and constants for the milestone-2 datapath stages.
package m2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_IN_0,
    S_LEAD_IN_1,
    S_WRITE,
    S_LEAD_OUT
  } ws_state_t;

  localparam int         BLOCK_WORDS   = 32;
  localparam int         WORDS_PER_ROW = 4;
  localparam logic [7:0] PIX_MAX       = 8'd255;

endpackage

// File: rtl/m2_clip8.sv
// Saturates one signed 16-bit IDCT sample to an 8-bit pixel in 0..255.
module m2_clip8
  import m2_pkg::*;
(
  input  logic [15:0] sample,
  output logic [7:0]  pixel
);

  always_comb begin
    pixel = sample[7:0];
    if (sample[15])
      pixel = 8'd0;
    else if (|sample[14:8])
      pixel = PIX_MAX;
  end

endmodule

// File: rtl/m2_ws.sv
// Write-S stage: streams one 8x8 block of clipped IDCT samples from DP RAM
// into SRAM as 8 rows of 4 packed pixel-pair words.
module m2_ws
  import m2_pkg::*;
#(
  parameter logic [6:0] DP_BASE = 7'd0
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [8:0]  Row_offset,
  input  logic [31:0] read_data_SP,
  output logic [6:0]  address_SP,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  localparam logic [6:0] DP_LAST  = DP_BASE + 7'(BLOCK_WORDS - 1);
  localparam logic [4:0] LAST_CNT = 5'(BLOCK_WORDS - 1);
  localparam logic [1:0] LAST_COL = 2'(WORDS_PER_ROW - 1);

  ws_state_t   state_reg;
  logic [4:0]  count_reg;
  logic [1:0]  col_reg;
  logic [17:0] jump_reg;
  logic [7:0]  pix_even;
  logic [7:0]  pix_odd;

  m2_clip8 u_clip_even (.sample(read_data_SP[31:16]), .pixel(pix_even));
  m2_clip8 u_clip_odd  (.sample(read_data_SP[15:0]),  .pixel(pix_odd));

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_reg       <= S_IDLE;
      address_SP      <= DP_BASE;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
      Done            <= 1'b0;
      count_reg       <= 5'd0;
      col_reg         <= 2'd0;
      jump_reg        <= 18'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          SRAM_we_n <= 1'b1;
          Done      <= 1'b0;
          if (Start) begin
            address_SP <= DP_BASE;
            state_reg  <= S_LEAD_IN_0;
          end
        end
        S_LEAD_IN_0: begin
          address_SP <= DP_BASE + 7'd1;
          state_reg  <= S_LEAD_IN_1;
        end
        S_LEAD_IN_1: begin
          address_SP <= DP_BASE + 7'd2;
          state_reg  <= S_WRITE;
        end
        S_WRITE: begin
          SRAM_address    <= Base_address + {16'd0, col_reg} + jump_reg;
          SRAM_write_data <= {pix_even, pix_odd};
          SRAM_we_n       <= 1'b0;
          // Reads run two words ahead of writes, so the address parks on the last word.
          if (address_SP != DP_LAST)
            address_SP <= address_SP + 7'd1;
          col_reg <= col_reg + 2'd1;
          if (col_reg == LAST_COL)
            jump_reg <= jump_reg + {9'd0, Row_offset};
          count_reg <= count_reg + 5'd1;
          if (count_reg == LAST_CNT)
            state_reg <= S_LEAD_OUT;
        end
        S_LEAD_OUT: begin
          SRAM_we_n  <= 1'b1;
          Done       <= 1'b1;
          count_reg  <= 5'd0;
          col_reg    <= 2'd0;
          jump_reg   <= 18'd0;
          address_SP <= DP_BASE;
          state_reg  <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m2_ws.sv
// Scoreboard bench for m2_ws: a Y-plane instance (DP_BASE=0) and a U-plane instance (DP_BASE=64).
module tb_m2_ws;

  logic        clk;
  logic        reset;
  logic [17:0] base_address;
  logic [8:0]  row_offset;
  logic        start        [2];
  logic [6:0]  address_sp   [2];
  logic [6:0]  addr_q       [2];
  logic [31:0] rdata        [2];
  logic [17:0] sram_address [2];
  logic [15:0] sram_wdata   [2];
  logic        sram_we_n    [2];
  logic        done         [2];

  logic [31:0] mem [128];
  logic [33:0] exp_q [$];
  logic [33:0] sb_entry;
  logic [15:0] wr_data_log [64];
  logic [17:0] wr_addr_log [64];
  int          nwr;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      m2_ws #(.DP_BASE(7'(gi * 64))) u_dut (
        .CLOCK_50       (clk),
        .Reset          (reset),
        .Start          (start[gi]),
        .Base_address   (base_address),
        .Row_offset     (row_offset),
        .read_data_SP   (rdata[gi]),
        .address_SP     (address_sp[gi]),
        .SRAM_address   (sram_address[gi]),
        .SRAM_write_data(sram_wdata[gi]),
        .SRAM_we_n      (sram_we_n[gi]),
        .Done           (done[gi])
      );
    end
  endgenerate

  // DP RAM read path: address captured on one edge, q presented on the next.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      addr_q[i] <= address_sp[i];
      rdata[i]  <= mem[addr_q[i]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clip_m(input logic [15:0] v);
    if (v[15]) return 8'd0;
    if (v > 16'd255) return 8'd255;
    return v[7:0];
  endfunction

  task automatic push_block(input int inst);
    logic [31:0] w;
    logic [17:0] a;
    for (int k = 0; k < 32; k++) begin
      w = mem[inst * 64 + k];
      a = base_address + 18'(k % 4) + 18'(k / 4) * {9'd0, row_offset};
      exp_q.push_back({a, clip_m(w[31:16]), clip_m(w[15:0])});
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sram_we_n[i] === 1'b0) begin
        $display("write inst=%0d addr=%0d data=%04h", i, sram_address[i], sram_wdata[i]);
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          sb_entry = exp_q.pop_front();
          check("wr_addr", 64'(sram_address[i]), 64'(sb_entry[33:16]));
          check("wr_data", 64'(sram_wdata[i]), 64'(sb_entry[15:0]));
        end
        if (nwr < 64) begin
          wr_data_log[nwr] = sram_wdata[i];
          wr_addr_log[nwr] = sram_address[i];
        end
        nwr++;
      end
    end
  end

  task automatic run_block(input int inst, input logic [17:0] base, input logic [8:0] ro,
                           input string tag);
    int first_low, lows, done_at, dones;
    base_address = base;
    row_offset   = ro;
    push_block(inst);
    nwr = 0;
    @(negedge clk);
    start[inst] = 1'b1;
    @(posedge clk);
    #1 start[inst] = 1'b0;
    first_low = -1; lows = 0; done_at = -1; dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (n == 0) check({tag, "_rd_addr0"}, 64'(address_sp[inst]), 64'(inst * 64));
      if (sram_we_n[inst] === 1'b0) begin
        if (first_low < 0) first_low = n;
        lows++;
      end
      if (done[inst] === 1'b1) begin
        if (done_at < 0) done_at = n;
        dones++;
      end
    end
    check({tag, "_first_write"}, 64'(first_low), 64'd3);
    check({tag, "_write_cycles"}, 64'(lows), 64'd32);
    check({tag, "_done_cycle"}, 64'(done_at), 64'd35);
    check({tag, "_done_width"}, 64'(dones), 64'd1);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_done(input int inst, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (done[inst] === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    checks = 0; errors = 0; nwr = 0;
    reset = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
    base_address = 18'd0; row_offset = 9'd160;
    for (int k = 0; k < 128; k++) mem[k] = 32'd0;
    for (int k = 0; k < 32; k++) mem[k] = {16'(k), 16'(k + 64)};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr_sp_y", 64'(address_sp[0]), 64'd0);
    check("rst_addr_sp_u", 64'(address_sp[1]), 64'd64);
    check("rst_sram_addr", 64'(sram_address[0]), 64'd0);
    check("rst_wdata", 64'(sram_wdata[0]), 64'd0);
    check("rst_we_n", 64'(sram_we_n[0]), 64'd1);
    check("rst_done", 64'(done[0]), 64'd0);
    reset = 1'b0;

    // Y block, ramp data
    run_block(0, 18'd0, 9'd160, "y_ramp");
    check("y_first_data", 64'(wr_data_log[0]), 64'h0040);
    check("y_last_data", 64'(wr_data_log[31]), 64'h1F5F);
    check("y_last_addr", 64'(wr_addr_log[31]), 64'd1123);
    check("y_row1_addr", 64'(wr_addr_log[4]), 64'd160);

    // clip corners followed by random samples
    mem[0] = {16'hFFF6, 16'd300};
    mem[1] = {16'd128, 16'd255};
    mem[2] = {16'h8000, 16'd0};
    for (int k = 3; k < 32; k++) mem[k] = $urandom;
    run_block(0, 18'd5000, 9'd160, "clip");
    check("clip_neg_big", 64'(wr_data_log[0]), 64'h00FF);
    check("clip_mid_max", 64'(wr_data_log[1]), 64'h80FF);
    check("clip_min_zero", 64'(wr_data_log[2]), 64'h0000);

    // reset after 10 writes
    base_address = 18'd200;
    push_block(0);
    nwr = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    for (int n = 0; n < 50 && nwr < 10; n++) begin
      @(negedge clk);
      #1;
    end
    check("abort_writes", 64'(nwr), 64'd10);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("abort_we_n", 64'(sram_we_n[0]), 64'd1);
    check("abort_done", 64'(done[0]), 64'd0);
    check("abort_addr_sp", 64'(address_sp[0]), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    run_block(0, 18'd200, 9'd160, "restart");
    check("restart_addr0", 64'(wr_addr_log[0]), 64'd200);

    // Start held through Done: back-to-back blocks
    base_address = 18'd1000;
    row_offset   = 9'd160;
    push_block(0);
    push_block(0);
    nwr = 0;
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, "b2b_first");
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, "b2b_second");
    repeat (3) @(negedge clk);
    check("b2b_writes", 64'(nwr), 64'd64);
    check("b2b_restart_addr", 64'(wr_addr_log[32]), 64'd1000);
    check("b2b_sb_empty", 64'(exp_q.size()), 64'd0);

    // U plane block from DP words 64..95
    for (int k = 64; k < 96; k++) mem[k] = $urandom;
    run_block(1, 18'd38400, 9'd80, "u_plane");
    check("u_last_addr", 64'(wr_addr_log[31]), 64'd38963);
    check("y_idle_during_u", 64'(sram_we_n[0]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
